// File: rtl/prio_rr_arbiter_pkg.sv
// Shared types and constants for the priority / round-robin arbiter.
// Latency: n/a (declarations only); backpressure: n/a.
package prio_arb_pkg;

  localparam int N_DEF    = 16;
  localparam int IDXW_DEF = 4;

  // Same "no winner" code the priority encoders emit.
  localparam logic [7:0] GNT_NONE = 8'hF0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/prio_rr_arbiter_if.sv
// Requester/grant bundle between the requesters and the arbiter; timeout_flag exists only with ARB_TIMEOUT_EN.
// Latency: none (wires); backpressure: grant is held until done or until the grantee's req drops.
interface prio_arb_if
  import prio_arb_pkg::*;
#(
  parameter int N = N_DEF
);

  logic         en;
  logic [N-1:0] req;
  logic         mode_rr;
  logic         done;
  logic         gnt_valid;
  logic [N-1:0] gnt_onehot;
  logic [7:0]   gnt_code;
`ifdef ARB_TIMEOUT_EN
  logic         timeout_flag;

  modport master (
    output en, req, mode_rr, done,
    input  gnt_valid, gnt_onehot, gnt_code, timeout_flag
  );

  modport slave (
    input  en, req, mode_rr, done,
    output gnt_valid, gnt_onehot, gnt_code, timeout_flag
  );
`else
  modport master (
    output en, req, mode_rr, done,
    input  gnt_valid, gnt_onehot, gnt_code
  );

  modport slave (
    input  en, req, mode_rr, done,
    output gnt_valid, gnt_onehot, gnt_code
  );
`endif

endinterface

// File: rtl/prio_rr_arbiter_pick.sv
// Combinational winner search: highest set index below start first, then highest overall.
// Latency: 0 cycles (pure logic); backpressure: none.
module prio_pick #(
  parameter int N    = 16,
  parameter int IDXW = 4
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] start,
  input  logic            mode_rr,
  output logic [IDXW-1:0] winner,
  output logic            any
);

  logic [N-1:0]    lo_mask;
  logic [N-1:0]    masked;
  logic [IDXW-1:0] win_all;
  logic [IDXW-1:0] win_masked;

  // Only indices strictly below start take part in the first pass; in fixed
  // mode the mask is empty so the search collapses to plain highest-wins.
  always_comb begin
    lo_mask = '0;
    for (int i = 0; i < N; i++) begin
      lo_mask[i] = mode_rr && (IDXW'(i) < start);
    end
  end

  assign masked = req & lo_mask;

  always_comb begin
    win_all    = '0;
    win_masked = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i])    win_all    = IDXW'(i);
      if (masked[i]) win_masked = IDXW'(i);
    end
  end

  assign any    = |req;
  assign winner = (|masked) ? win_masked : win_all;

endmodule

// File: rtl/prio_rr_arbiter.sv
// Hold-until-release arbiter, fixed or round-robin priority; ARB_TIMEOUT_EN adds a HOLD_MAX grant limit and timeout_flag.
// Latency: grant registered 1 cycle after req seen in IDLE; backpressure: grant held until done/req drop, then RELEASE + IDLE gap.
module prio_rr_arbiter
  import prio_arb_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int IDXW     = IDXW_DEF,
  parameter int HOLD_MAX = 255
) (
  input logic       clk,
  input logic       rst_n,
  prio_arb_if.slave bus
);

  if (N < 2 || N > 16) begin : g_bad_n
    $error("prio_rr_arbiter: N must be in 2..16");
  end
  if (IDXW != $clog2(N)) begin : g_bad_idxw
    $error("prio_rr_arbiter: IDXW must equal clog2(N)");
  end
  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold
    $error("prio_rr_arbiter: HOLD_MAX must be in 1..255");
  end

  arb_state_t      state_q, state_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [IDXW-1:0] winner_q, winner_d;
  logic            gnt_valid_q, gnt_valid_d;
  logic [N-1:0]    gnt_onehot_q, gnt_onehot_d;
  logic [7:0]      gnt_code_q, gnt_code_d;

  logic [IDXW-1:0] pick_win;
  logic            pick_any;
  logic            release_now;
  logic            force_rel;

  prio_pick #(
    .N    (N),
    .IDXW (IDXW)
  ) u_pick (
    .req     (bus.req),
    .start   (ptr_q),
    .mode_rr (bus.mode_rr),
    .winner  (pick_win),
    .any     (pick_any)
  );

  assign release_now = bus.done || !bus.req[winner_q];

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic       timeout_q, timeout_d;

  assign force_rel = (hold_cnt_q == 8'(HOLD_MAX - 1));

  // Counter is only meaningful in GRANT; a natural release wins over a
  // coincident timeout so the sticky flag marks forced releases only.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    timeout_d  = timeout_q;
    if (state_q == IDLE) begin
      hold_cnt_d = '0;
    end else if (state_q == GRANT) begin
      hold_cnt_d = hold_cnt_q + 8'd1;
      if (force_rel && !release_now) timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.timeout_flag = timeout_q;
`else
  assign force_rel = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    winner_d     = winner_q;
    gnt_valid_d  = gnt_valid_q;
    gnt_onehot_d = gnt_onehot_q;
    gnt_code_d   = gnt_code_q;
    unique case (state_q)
      IDLE: begin
        if (bus.en && pick_any) begin
          state_d      = GRANT;
          winner_d     = pick_win;
          gnt_valid_d  = 1'b1;
          gnt_onehot_d = N'(1) << pick_win;
          gnt_code_d   = 8'(pick_win);
        end
      end
      GRANT: begin
        if (release_now || force_rel) begin
          state_d      = RELEASE;
          gnt_valid_d  = 1'b0;
          gnt_onehot_d = '0;
          gnt_code_d   = GNT_NONE;
        end
      end
      RELEASE: begin
        // Pointer follows the last winner in both modes so a later switch
        // to round-robin starts just below whoever was served last.
        ptr_d   = winner_q;
        state_d = IDLE;
      end
      default: begin
        state_d      = IDLE;
        gnt_valid_d  = 1'b0;
        gnt_onehot_d = '0;
        gnt_code_d   = GNT_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      winner_q     <= '0;
      gnt_valid_q  <= 1'b0;
      gnt_onehot_q <= '0;
      gnt_code_q   <= GNT_NONE;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      winner_q     <= winner_d;
      gnt_valid_q  <= gnt_valid_d;
      gnt_onehot_q <= gnt_onehot_d;
      gnt_code_q   <= gnt_code_d;
    end
  end

  assign bus.gnt_valid  = gnt_valid_q;
  assign bus.gnt_onehot = gnt_onehot_q;
  assign bus.gnt_code   = gnt_code_q;

endmodule

// File: tb/tb_prio_rr_arbiter.sv
// Directed bench for prio_rr_arbiter; the timeout section builds only with ARB_TIMEOUT_EN.
// Inputs change 1 ns after a rising edge, outputs are sampled at that same point.
module tb_prio_rr_arbiter;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  prio_arb_if #(.N(16)) bus ();

  prio_rr_arbiter #(
    .N        (16),
    .IDXW     (4),
    .HOLD_MAX (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_vld"},  32'(bus.gnt_valid),  32'd0);
    chk({tag, "_code"}, 32'(bus.gnt_code),   32'hF0);
    chk({tag, "_oh"},   32'(bus.gnt_onehot), 32'h0);
  endtask

  task automatic chk_gnt(input string tag, input int idx);
    chk({tag, "_vld"},  32'(bus.gnt_valid),  32'd1);
    chk({tag, "_code"}, 32'(bus.gnt_code),   32'(idx));
    chk({tag, "_oh"},   32'(bus.gnt_onehot), 32'd1 << idx);
  endtask

  initial begin
    int rr_exp [4];
    rr_exp = '{15, 8, 0, 15};
    n_checks = 0;
    n_errors = 0;

    // Reset and no requests
    rst_n       = 1'b0;
    bus.en      = 1'b0;
    bus.req     = '0;
    bus.mode_rr = 1'b0;
    bus.done    = 1'b0;
    #12;
    chk_idle("reset");
`ifdef ARB_TIMEOUT_EN
    chk("reset_tmo", 32'(bus.timeout_flag), 32'd0);
`endif
    rst_n  = 1'b1;
    bus.en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk_idle("noreq");
    end

    // Round-robin from ptr=0: 15, 8, 0, 15 with a gap between grants
    bus.mode_rr = 1'b1;
    bus.req     = 16'h8101;
    for (int g = 0; g < 4; g++) begin
      step();
      chk_gnt("rr_gnt", rr_exp[g]);
      bus.done = 1'b1;
      step();
      chk_idle("rr_rel");
      bus.done = 1'b0;
      step();
      chk_idle("rr_gap");
    end
    bus.req = '0;

    // Fixed priority: 0x0204 -> 9, released by done, regranted
    bus.mode_rr = 1'b0;
    bus.req     = 16'h0204;
    step();
    chk_gnt("fix_gnt", 9);
    bus.done = 1'b1;
    step();
    chk_idle("fix_rel");
    bus.done = 1'b0;
    step();
    chk_idle("fix_gap");
    step();
    chk_gnt("fix_regnt", 9);
    // en low and other req bits toggling leave the held grant alone
    bus.en  = 1'b0;
    bus.req = 16'hFFFF;
    step();
    chk_gnt("fix_hold", 9);
    // req drop together with done: one release only
    bus.req  = '0;
    bus.done = 1'b1;
    step();
    chk_idle("both_rel");
    bus.done = 1'b0;
    bus.en   = 1'b1;
    step();
    chk_idle("both_gap");
    step();
    chk_idle("both_after");

    // Release by req drop, then en gating
    bus.req = 16'h0008;
    step();
    chk_gnt("drop_gnt", 3);
    bus.req = '0;
    step();
    chk_idle("drop_rel");
    bus.en  = 1'b0;
    bus.req = 16'h0010;
    step();
    chk_idle("en0_a");
    step();
    chk_idle("en0_b");
    bus.en = 1'b1;
    step();
    chk_gnt("en1_gnt", 4);
    bus.req = '0;
    step();
    step();

    // Move ptr to 15, then reset asynchronously in the middle of a grant on 7
    bus.req = 16'h8000;
    step();
    chk_gnt("pre_gnt15", 15);
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    bus.req  = 16'h0080;
    step();
    step();
    chk_gnt("pre_gnt7", 7);
    #3;
    rst_n = 1'b0;
    #1;
    chk_idle("async_rst");
    bus.mode_rr = 1'b1;
    bus.req     = 16'h8080;
    #10;
    rst_n = 1'b1;
    step();
    chk_gnt("rst_rr", 15);
    bus.req = '0;
    step();
    step();

`ifdef ARB_TIMEOUT_EN
    // Timeout: grant on 1 is held exactly 4 cycles, then forced off
    bus.mode_rr = 1'b0;
    bus.req     = 16'h0002;
    for (int c = 0; c < 4; c++) begin
      step();
      chk_gnt("tmo_hold", 1);
      chk("tmo_flag0", 32'(bus.timeout_flag), 32'd0);
    end
    step();
    chk_idle("tmo_rel");
    chk("tmo_flag1", 32'(bus.timeout_flag), 32'd1);
    step();
    chk_idle("tmo_gap");
    step();
    chk_gnt("tmo_regnt", 1);
    chk("tmo_sticky", 32'(bus.timeout_flag), 32'd1);
    bus.req = '0;
    step();
    step();
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/prio_rr_arbiter.md
Name: prio_rr_arbiter

Overview:
- Sequential arbiter that shares one downstream resource among N requesters.
- Selects a winner using a priority search in which the higher index wins, then holds that grant until the grantee releases it.
- Two modes: fixed priority, or round-robin with a rotating start point.
- Sits between the requester lines and the shared resource. Its 8-bit grant code uses the same encoding as the team's priority-encoder outputs: winner index, or 8'hF0 when there is no grant.

Parameters:
- N, 16, number of requesters (2..16).
- IDXW, 4, width of the grant index; equals clog2(N).
- HOLD_MAX, 255, maximum grant-hold cycles; used only when ARB_TIMEOUT_EN is defined; range 1..255.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  arbitration enable. When 0, no new grant is issued; an existing grant is kept.
- req  input  N  request lines, level-sensitive, one bit per requester.
- mode_rr  input  1  0 = fixed priority, 1 = round-robin; sampled only in IDLE.
- done  input  1  single-cycle pulse from the current grantee: release the grant.
- gnt_valid  output  1  a grant is active.
- gnt_onehot  output  N  one-hot grant vector; all zeros when gnt_valid=0.
- gnt_code  output  8  zero-extended winner index when gnt_valid=1, else 8'hF0.

Behaviour:
- Reset values (asynchronous):
  - state = IDLE, ptr = 0, gnt_valid = 0, gnt_onehot = 0, gnt_code = 8'hF0, hold counter = 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- States: IDLE, GRANT, RELEASE.
- IDLE:
  - If en=1 and req≠0, the winner is latched and the state moves to GRANT on the same edge.
  - gnt_valid is high in the cycle after req is first seen (latency = 1 cycle).
- Winner search:
  - Fixed mode: the highest set index wins.
  - Round-robin mode: the search order is ptr-1, ptr-2, …, 0, N-1, …, ptr (mod N); the first set bit wins.
  - With ptr=0 the round-robin order equals the fixed order.
- GRANT:
  - Outputs stay stable.
  - Go to RELEASE when done=1 or req[winner]=0, whichever occurs first.
  - Changes on other req bits are ignored.
- RELEASE (exactly 1 cycle):
  - gnt_valid = 0, gnt_onehot = 0, gnt_code = 8'hF0.
  - ptr <= winner. ptr updates in both modes, so switching to round-robin resumes fairly.
  - Next state is always IDLE, which guarantees one idle gap cycle between consecutive grants.
- Boundaries:
  - done asserted while in IDLE or RELEASE is ignored.
  - en=0 while in GRANT has no effect on the held grant.
  - req dropping in the same cycle as done gives a single release, not two.
  - If the winner is N-1, round-robin wraps its search to start at N-2.
  - rst_n asserted mid-grant clears the grant immediately (asynchronous) and resets ptr to 0.
- Arithmetic:
  - ptr is IDXW bits wide; the modular decrement wraps to N-1 even when N is not a power of two.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- When defined:
  - An 8-bit hold counter clears on entry to GRANT and increments each cycle in GRANT.
  - When count = HOLD_MAX-1 and no release has occurred, the state is forced to RELEASE. gnt_valid therefore stays high for exactly HOLD_MAX cycles.
  - A sticky output, timeout_flag (1 bit), is added. It is set on a forced release and cleared on reset only.
- When undefined:
  - No counter and no timeout_flag port.
  - A grant is held indefinitely until done or until the grantee's req drops.

Decomposition:
- Shared package prio_arb_pkg contains:
  - State enum {IDLE, GRANT, RELEASE}.
  - Constant GNT_NONE = 8'hF0.
  - Default N and IDXW.
- One combinational sub-module, prio_pick:
  - Inputs: req vector, start pointer, mode.
  - Outputs: winner index and an any-set flag.
  - Implements the masked double-pass priority search.
- The FSM, registers and the optional counter live in the top module.

Test Plan:
- Reset / no request: hold rst_n=0, release; req=0 for 10 cycles -> gnt_valid=0, gnt_code=8'hF0 throughout.
- Fixed priority: mode_rr=0, req=16'h0204 -> next cycle gnt_code=9, gnt_onehot=16'h0200. Pulse done -> 1 cycle with gnt_code=8'hF0 -> then gnt_code=9 again.
- Round-robin: mode_rr=1, req=16'h8101, each grant released by done -> grant sequence 15, 8, 0, 15, with one idle cycle between grants.
- Release by req drop, and en: grant 3 with req=16'h0008, then clear req[3] -> RELEASE next cycle. Set en=0, req=16'h0010 -> no grant. Set en=1 -> gnt_code=4.
- Async reset mid-grant: gnt_code=7 active; pull rst_n low between edges -> gnt_valid=0 and gnt_code=8'hF0 immediately. After reset, round-robin with req=16'h8080 -> first grant is 15 (ptr=0).
- Timeout (ARB_TIMEOUT_EN, HOLD_MAX=4): req=16'h0002 held, done never pulsed -> gnt_valid high for exactly 4 cycles, timeout_flag=1, regrant to 1 after the release cycle.
